trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
Trap sequencer sitting directly upstream of the CSR register file. It arbitrates synchronous exceptions from the commit stage, synchronised external/timer/software interrupt lines, and MRET. It then produces the one-cycle trap strobe with cause and MEPC for the CSR file. It also drives the pipeline flush/stall and the fetch redirect to the trap vector (from the CSR file's MTVEC output) or back to MEPC.

Parameters:
XLEN, 32, data/address width
SYNC_STAGES, 2, flop stages on each interrupt input (min 2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
commit_valid_i  in  1  instruction at commit this cycle
commit_pc_i  in  XLEN  PC of committing instruction
exc_instr_misaligned_i  in  1  exception flag, cause 0
exc_illegal_i  in  1  exception flag, cause 2
exc_ebreak_i  in  1  exception flag, cause 3
exc_ecall_i  in  1  exception flag, cause 11
exc_load_misaligned_i  in  1  exception flag, cause 4
exc_store_misaligned_i  in  1  exception flag, cause 6
mret_i  in  1  committing instruction is MRET
irq_software_i  in  1  async level, MSIP
irq_timer_i  in  1  async level, MTIP
irq_external_i  in  1  async level, MEIP
mstatus_mie_i  in  1  global interrupt enable
mie_i  in  XLEN  CSR MIE (bits 3/7/11 used)
mtvec_i  in  XLEN  CSR MTVEC
mepc_i  in  XLEN  CSR MEPC
trap_active_o  out  1  one-cycle trap strobe to CSR file
trap_cause_o  out  XLEN  mcause value
trap_mepc_o  out  XLEN  mepc value
mret_o  out  1  one-cycle MRET strobe to CSR file (restore MIE)
flush_o  out  1  kill committing instruction and younger
stall_o  out  1  freeze pipeline
redirect_valid_o  out  1  fetch redirect request
redirect_pc_o  out  XLEN  redirect target
redirect_ready_i  in  1  fetch accepted redirect

Behaviour:
- Reset: state IDLE; sync flops, trap_active_o, trap_cause_o, trap_mepc_o, mret_o, redirect_valid_o, redirect_pc_o = 0. flush_o/stall_o = 0. Reset mid-sequence aborts immediately to IDLE with no strobes.
- Interrupt pending: irq_pend[k] = synced line AND mie_i[k] AND mstatus_mie_i. Sync latency SYNC_STAGES cycles.
- Priority (evaluated only in IDLE with commit_valid_i=1): exception > interrupt > MRET.
  - Exceptions: instr_misaligned > illegal > ebreak > ecall > load_misaligned > store_misaligned.
  - Interrupts: external(11) > software(3) > timer(7); cause has bit XLEN-1 set.
- Detection cycle N (IDLE): flush_o=1 combinationally. Committing instruction is squashed for both exception and interrupt. Register cause and mepc=commit_pc_i. Go to TRAP.
- TRAP (N+1): trap_active_o=1 exactly one cycle; cause/mepc valid; flush_o=1, stall_o=1. Go to REDIRECT with redirect_pc_o = {mtvec_i[XLEN-1:2],2'b00}.
- MRET detect (IDLE, no exception/interrupt): flush_o=1. Go to RETURN. RETURN: mret_o=1 one cycle, stall_o=1. Go to REDIRECT with redirect_pc_o=mepc_i sampled this cycle.
- REDIRECT: redirect_valid_o=1 and redirect_pc_o held stable, stall_o=1, until redirect_ready_i=1. Next cycle IDLE, all outputs low.
- Events arriving outside IDLE are ignored. Interrupt levels are re-evaluated on the first IDLE cycle.
- commit_valid_i=0: no trap, no MRET taken, even if interrupts are pending.
- Multiple exception flags at once: single highest-priority cause only.
- Outputs other than the strobes hold their last value when not asserted.

Optional Feature:
TRAP_VECTORED_EN: when defined and mtvec_i[1:0]==2'b01 and the trap is an interrupt, redirect_pc_o = base + 4*cause[XLEN-2:0]; exceptions still use base. When undefined, redirect_pc_o is always base and mtvec_i[1:0] is ignored.

Test Plan:
- exc_illegal_i=1, commit_pc_i=0x0000_0100, mtvec_i=0x0000_0800, ready=1 -> flush at N; trap_active_o at N+1 with cause=2, mepc=0x100; redirect 0x800 at N+2; IDLE at N+3.
- exc_ecall_i and exc_load_misaligned_i together -> cause=11 only, single trap_active_o pulse.
- irq_timer_i=1, mie_i[7]=1, mstatus_mie_i=1, commit at 0x200 after SYNC_STAGES -> cause=0x8000_0007, mepc=0x200; same with mstatus_mie_i=0 -> no trap.
- mret_i with mepc_i=0x0000_0104, redirect_ready_i low 3 cycles -> mret_o one pulse; redirect_valid_o held 3 cycles at 0x104 then IDLE.
- TRAP_VECTORED_EN, mtvec_i=0x0000_0801, irq_external_i -> redirect 0x0000_082C; illegal instruction -> 0x0000_0800.
- rst_i asserted in REDIRECT -> next cycle all outputs 0, state IDLE, no further strobes.

Source files
------------

// File: rtl/trap_ctrl.sv
// Trap sequencer ahead of the CSR file: arbitrates commit-stage exceptions, interrupts and MRET.
// Define TRAP_VECTORED_EN to enable vectored interrupt targets when mtvec_i[1:0] == 2'b01.
module trap_ctrl #(
    parameter int XLEN        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            commit_valid_i,
    input  logic [XLEN-1:0] commit_pc_i,
    input  logic            exc_instr_misaligned_i,
    input  logic            exc_illegal_i,
    input  logic            exc_ebreak_i,
    input  logic            exc_ecall_i,
    input  logic            exc_load_misaligned_i,
    input  logic            exc_store_misaligned_i,
    input  logic            mret_i,
    input  logic            irq_software_i,
    input  logic            irq_timer_i,
    input  logic            irq_external_i,
    input  logic            mstatus_mie_i,
    input  logic [XLEN-1:0] mie_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            trap_active_o,
    output logic [XLEN-1:0] trap_cause_o,
    output logic [XLEN-1:0] trap_mepc_o,
    output logic            mret_o,
    output logic            flush_o,
    output logic            stall_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    input  logic            redirect_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRAP,
        S_RETURN,
        S_REDIRECT
    } state_e;

    localparam logic [XLEN-1:0] IRQ_FLAG = {1'b1, {(XLEN-1){1'b0}}};

    state_e state_q, state_d;

    // Interrupt lines packed as {external, timer, software}.
    logic [2:0] irq_raw;
    logic [2:0] irq_sync_q [SYNC_STAGES];
    logic [2:0] irq_sync;
    logic [2:0] irq_pend;

    assign irq_raw = {irq_external_i, irq_timer_i, irq_software_i};

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) irq_sync_q[i] <= '0;
        end else begin
            irq_sync_q[0] <= irq_raw;
            for (int i = 1; i < SYNC_STAGES; i++) irq_sync_q[i] <= irq_sync_q[i-1];
        end
    end

    assign irq_sync = irq_sync_q[SYNC_STAGES-1];
    assign irq_pend = irq_sync & {mie_i[11], mie_i[7], mie_i[3]} & {3{mstatus_mie_i}};

    logic            exc_valid;
    logic [XLEN-1:0] exc_cause;
    logic            irq_valid;
    logic [XLEN-1:0] irq_cause;

    always_comb begin
        // NOTE: defaults first so no path through the block leaves a variable unassigned (no latch).
        exc_valid = 1'b1;
        exc_cause = '0;
        if (exc_instr_misaligned_i)      exc_cause = XLEN'(0);
        else if (exc_illegal_i)          exc_cause = XLEN'(2);
        else if (exc_ebreak_i)           exc_cause = XLEN'(3);
        else if (exc_ecall_i)            exc_cause = XLEN'(11);
        else if (exc_load_misaligned_i)  exc_cause = XLEN'(4);
        else if (exc_store_misaligned_i) exc_cause = XLEN'(6);
        else                             exc_valid = 1'b0;
    end

    always_comb begin
        irq_valid = 1'b1;
        irq_cause = '0;
        if (irq_pend[2])      irq_cause = IRQ_FLAG | XLEN'(11);
        else if (irq_pend[0]) irq_cause = IRQ_FLAG | XLEN'(3);
        else if (irq_pend[1]) irq_cause = IRQ_FLAG | XLEN'(7);
        else                  irq_valid = 1'b0;
    end

    logic take_trap;
    logic take_mret;

    assign take_trap = commit_valid_i & (exc_valid | irq_valid);
    assign take_mret = commit_valid_i & mret_i & ~exc_valid & ~irq_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        flush_o          = 1'b0;
        stall_o          = 1'b0;
        trap_active_o    = 1'b0;
        mret_o           = 1'b0;
        redirect_valid_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (take_trap) begin
                    flush_o = 1'b1;
                    state_d = S_TRAP;
                end else if (take_mret) begin
                    flush_o = 1'b1;
                    state_d = S_RETURN;
                end
            end
            S_TRAP: begin
                trap_active_o = 1'b1;
                flush_o       = 1'b1;
                stall_o       = 1'b1;
                state_d       = S_REDIRECT;
            end
            S_RETURN: begin
                mret_o  = 1'b1;
                stall_o = 1'b1;
                state_d = S_REDIRECT;
            end
            S_REDIRECT: begin
                redirect_valid_o = 1'b1;
                stall_o          = 1'b1;
                if (redirect_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [XLEN-1:0] vec_base;
    logic [XLEN-1:0] trap_target;

    assign vec_base = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    logic vec_mode;
    logic unused_bits;

    assign vec_mode    = (mtvec_i[1:0] == 2'b01) && trap_cause_o[XLEN-1];
    assign trap_target = vec_mode ? vec_base + {trap_cause_o[XLEN-3:0], 2'b00} : vec_base;
    assign unused_bits = ^{mie_i[XLEN-1:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};
`else
    logic unused_bits;

    assign trap_target = vec_base;
    assign unused_bits = ^{mie_i[XLEN-1:12], mie_i[10:8], mie_i[6:4], mie_i[2:0], mtvec_i[1:0]};
`endif

    // Cause/mepc latch on detection; the redirect target latches on the way into REDIRECT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trap_cause_o  <= '0;
            trap_mepc_o   <= '0;
            redirect_pc_o <= '0;
        end else begin
            if (state_q == S_IDLE && take_trap) begin
                trap_cause_o <= exc_valid ? exc_cause : irq_cause;
                trap_mepc_o  <= commit_pc_i;
            end
            if (state_q == S_TRAP)        redirect_pc_o <= trap_target;
            else if (state_q == S_RETURN) redirect_pc_o <= mepc_i;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: scoreboard of expected strobes plus cycle-level checks.
// Honours TRAP_VECTORED_EN when computing expected redirect targets.
module tb_trap_ctrl;

    localparam int XLEN        = 32;
    localparam int SYNC_STAGES = 2;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            commit_valid_i;
    logic [XLEN-1:0] commit_pc_i;
    logic            exc_instr_misaligned_i, exc_illegal_i, exc_ebreak_i;
    logic            exc_ecall_i, exc_load_misaligned_i, exc_store_misaligned_i;
    logic            mret_i;
    logic            irq_software_i, irq_timer_i, irq_external_i;
    logic            mstatus_mie_i;
    logic [XLEN-1:0] mie_i, mtvec_i, mepc_i;
    logic            trap_active_o;
    logic [XLEN-1:0] trap_cause_o, trap_mepc_o;
    logic            mret_o, flush_o, stall_o, redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            redirect_ready_i;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(XLEN), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk_i                  (clk),
        .rst_i                  (rst_i),
        .commit_valid_i         (commit_valid_i),
        .commit_pc_i            (commit_pc_i),
        .exc_instr_misaligned_i (exc_instr_misaligned_i),
        .exc_illegal_i          (exc_illegal_i),
        .exc_ebreak_i           (exc_ebreak_i),
        .exc_ecall_i            (exc_ecall_i),
        .exc_load_misaligned_i  (exc_load_misaligned_i),
        .exc_store_misaligned_i (exc_store_misaligned_i),
        .mret_i                 (mret_i),
        .irq_software_i         (irq_software_i),
        .irq_timer_i            (irq_timer_i),
        .irq_external_i         (irq_external_i),
        .mstatus_mie_i          (mstatus_mie_i),
        .mie_i                  (mie_i),
        .mtvec_i                (mtvec_i),
        .mepc_i                 (mepc_i),
        .trap_active_o          (trap_active_o),
        .trap_cause_o           (trap_cause_o),
        .trap_mepc_o            (trap_mepc_o),
        .mret_o                 (mret_o),
        .flush_o                (flush_o),
        .stall_o                (stall_o),
        .redirect_valid_o       (redirect_valid_o),
        .redirect_pc_o          (redirect_pc_o),
        .redirect_ready_i       (redirect_ready_i)
    );

    typedef struct {
        bit          is_mret;
        logic [31:0] cause;
        logic [31:0] mepc;
        logic [31:0] rpc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] cur_rpc = '0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          trap_cnt = 0;
    int          mret_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rpc(input logic [31:0] mtvec, input logic [31:0] cause);
        logic [31:0] base;
        base = {mtvec[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
        if (mtvec[1:0] == 2'b01 && cause[31]) return base + (cause & 32'h7FFF_FFFF) * 4;
`endif
        return base;
    endfunction

    task automatic expect_trap(input logic [31:0] cause, input logic [31:0] pc);
        exp_t e;
        e.is_mret = 1'b0;
        e.cause   = cause;
        e.mepc    = pc;
        e.rpc     = exp_rpc(mtvec_i, cause);
        sb.push_back(e);
    endtask

    // Monitor: pops the scoreboard on each strobe and checks the redirect target on handshake.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (trap_active_o) trap_cnt++;
            if (mret_o) mret_cnt++;
            if (trap_active_o || mret_o) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("strobe_kind", 32'(mret_o), 32'(mon_e.is_mret));
                    if (trap_active_o) begin
                        check("trap_cause", trap_cause_o, mon_e.cause);
                        check("trap_mepc", trap_mepc_o, mon_e.mepc);
                    end
                    cur_rpc = mon_e.rpc;
                end
            end
            if (redirect_valid_o && redirect_ready_i) check("redirect_pc", redirect_pc_o, cur_rpc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One commit cycle; checks flush_o in the detection cycle, then clears the commit inputs.
    task automatic drive_commit(input logic [31:0] pc, input logic [5:0] exc, input logic mret,
                                input logic exp_flush, input string tag);
        step();
        commit_valid_i = 1'b1;
        commit_pc_i    = pc;
        {exc_instr_misaligned_i, exc_illegal_i, exc_ebreak_i,
         exc_ecall_i, exc_load_misaligned_i, exc_store_misaligned_i} = exc;
        mret_i = mret;
        @(negedge clk);
        check(tag, 32'(flush_o), 32'(exp_flush));
        step();
        commit_valid_i = 1'b0;
        {exc_instr_misaligned_i, exc_illegal_i, exc_ebreak_i,
         exc_ecall_i, exc_load_misaligned_i, exc_store_misaligned_i} = 6'b0;
        mret_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stall_o && !flush_o) return;
        end
        check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_trap_active"}, 32'(trap_active_o), 32'd0);
        check({tag, "_cause"}, trap_cause_o, 32'd0);
        check({tag, "_mepc"}, trap_mepc_o, 32'd0);
        check({tag, "_mret"}, 32'(mret_o), 32'd0);
        check({tag, "_flush"}, 32'(flush_o), 32'd0);
        check({tag, "_stall"}, 32'(stall_o), 32'd0);
        check({tag, "_rvalid"}, 32'(redirect_valid_o), 32'd0);
        check({tag, "_rpc"}, redirect_pc_o, 32'd0);
    endtask

    logic [5:0]  exc_tab   [6] = '{6'b111111, 6'b011000, 6'b001100, 6'b000110, 6'b000011, 6'b000001};
    logic [31:0] cause_tab [6] = '{32'd0, 32'd2, 32'd3, 32'd11, 32'd4, 32'd6};

    initial begin
        int cnt0;
        rst_i = 1'b1;
        commit_valid_i = 1'b0;
        commit_pc_i = '0;
        {exc_instr_misaligned_i, exc_illegal_i, exc_ebreak_i,
         exc_ecall_i, exc_load_misaligned_i, exc_store_misaligned_i} = 6'b0;
        mret_i = 1'b0;
        {irq_software_i, irq_timer_i, irq_external_i} = 3'b0;
        mstatus_mie_i = 1'b0;
        mie_i = '0;
        mtvec_i = 32'h0000_0800;
        mepc_i = '0;
        redirect_ready_i = 1'b1;
        repeat (3) step();
        rst_i = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Illegal instruction: cycle-exact sequence
        expect_trap(32'd2, 32'h0000_0100);
        drive_commit(32'h0000_0100, 6'b010000, 1'b0, 1'b1, "illegal_flush_n");
        @(negedge clk);
        check("illegal_trap_active_n1", 32'(trap_active_o), 32'd1);
        check("illegal_flush_n1", 32'(flush_o), 32'd1);
        check("illegal_stall_n1", 32'(stall_o), 32'd1);
        step();
        @(negedge clk);
        check("illegal_rvalid_n2", 32'(redirect_valid_o), 32'd1);
        check("illegal_rpc_n2", redirect_pc_o, 32'h0000_0800);
        check("illegal_trap_active_n2", 32'(trap_active_o), 32'd0);
        step();
        @(negedge clk);
        check("illegal_rvalid_n3", 32'(redirect_valid_o), 32'd0);
        check("illegal_stall_n3", 32'(stall_o), 32'd0);
        check("illegal_cause_hold", trap_cause_o, 32'd2);
        check("illegal_mepc_hold", trap_mepc_o, 32'h0000_0100);

        // Exception priority table, one trap pulse per commit
        for (int i = 0; i < 6; i++) begin
            cnt0 = trap_cnt;
            expect_trap(cause_tab[i], 32'h0000_1000 + 32'(i * 4));
            drive_commit(32'h0000_1000 + 32'(i * 4), exc_tab[i], 1'b0, 1'b1, "exc_flush");
            wait_idle();
            check("exc_single_pulse", 32'(trap_cnt - cnt0), 32'd1);
        end

        // Timer interrupt: no trap while commit_valid_i is low, then taken on commit
        mie_i = 32'h0000_0080;
        mstatus_mie_i = 1'b1;
        irq_timer_i = 1'b1;
        cnt0 = trap_cnt;
        repeat (SYNC_STAGES + 2) begin
            step();
            @(negedge clk);
            check("irq_no_commit_flush", 32'(flush_o), 32'd0);
        end
        check("irq_no_commit_trap", 32'(trap_cnt - cnt0), 32'd0);
        expect_trap(32'h8000_0007, 32'h0000_0200);
        drive_commit(32'h0000_0200, 6'b0, 1'b0, 1'b1, "irq_timer_flush");
        wait_idle();
        mstatus_mie_i = 1'b0;
        cnt0 = trap_cnt;
        drive_commit(32'h0000_0204, 6'b0, 1'b0, 1'b0, "irq_masked_flush");
        repeat (3) step();
        check("irq_masked_no_trap", 32'(trap_cnt - cnt0), 32'd0);
        irq_timer_i = 1'b0;
        mstatus_mie_i = 1'b1;
        repeat (SYNC_STAGES + 2) step();

        // MRET with a slow fetch; mepc_i changes while the redirect is pending
        cnt0 = mret_cnt;
        mepc_i = 32'h0000_0104;
        redirect_ready_i = 1'b0;
        sb.push_back('{is_mret: 1'b1, cause: 32'd0, mepc: 32'd0, rpc: 32'h0000_0104});
        drive_commit(32'h0000_0180, 6'b0, 1'b1, 1'b1, "mret_flush");
        @(negedge clk);
        check("mret_strobe", 32'(mret_o), 32'd1);
        check("mret_stall", 32'(stall_o), 32'd1);
        check("mret_no_trap", 32'(trap_active_o), 32'd0);
        step();
        mepc_i = 32'hDEAD_BEE0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mret_rvalid_hold", 32'(redirect_valid_o), 32'd1);
            check("mret_rpc_hold", redirect_pc_o, 32'h0000_0104);
            step();
        end
        redirect_ready_i = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        check("mret_idle_rvalid", 32'(redirect_valid_o), 32'd0);
        check("mret_idle_stall", 32'(stall_o), 32'd0);
        check("mret_single_pulse", 32'(mret_cnt - cnt0), 32'd1);

        // Interrupt priority and vectored targets
        mtvec_i = 32'h0000_0801;
        mie_i = 32'h0000_0888;
        irq_software_i = 1'b1;
        irq_timer_i = 1'b1;
        repeat (SYNC_STAGES + 1) step();
        expect_trap(32'h8000_0003, 32'h0000_0300);
        drive_commit(32'h0000_0300, 6'b0, 1'b0, 1'b1, "irq_sw_flush");
        wait_idle();
        irq_external_i = 1'b1;
        repeat (SYNC_STAGES + 1) step();
        expect_trap(32'h8000_000B, 32'h0000_0304);
        drive_commit(32'h0000_0304, 6'b0, 1'b0, 1'b1, "irq_ext_flush");
        wait_idle();
        expect_trap(32'd2, 32'h0000_0308);
        drive_commit(32'h0000_0308, 6'b010000, 1'b1, 1'b1, "exc_over_irq_flush");
        wait_idle();
        {irq_software_i, irq_timer_i, irq_external_i} = 3'b0;
        repeat (SYNC_STAGES + 2) step();
        mtvec_i = 32'h0000_0800;

        // Reset while waiting in REDIRECT
        redirect_ready_i = 1'b0;
        expect_trap(32'd2, 32'h0000_0500);
        drive_commit(32'h0000_0500, 6'b010000, 1'b0, 1'b1, "rst_seq_flush");
        step();
        @(negedge clk);
        check("rst_seq_in_redirect", 32'(redirect_valid_o), 32'd1);
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid");
        cnt0 = trap_cnt + mret_cnt;
        repeat (4) step();
        check("rst_no_strobes", 32'(trap_cnt + mret_cnt - cnt0), 32'd0);
        check("rst_stays_idle", 32'(redirect_valid_o | stall_o), 32'd0);
        redirect_ready_i = 1'b1;

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
